// File: rtl/register_file.sv
// 32 x 32 general-purpose register file: two synchronous read ports, one write port,
// same-edge write-to-read forwarding, register 0 hardwired to zero.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en0,
    input  logic [ADDR_W-1:0] rd_addr0,
    output logic [DATA_W-1:0] rd_data0,
    input  logic              rd_en1,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              wr_live;
    logic [DATA_W-1:0] next_data0;
    logic [DATA_W-1:0] next_data1;

    // A write to r0 never lands and never forwards, so it is filtered once here.
    assign wr_live = wr_en && (wr_addr != '0);

    always_comb begin
        next_data0 = mem[rd_addr0];
        if (rd_addr0 == '0) begin
            next_data0 = '0;
        end else if (wr_live && (wr_addr == rd_addr0)) begin
            next_data0 = wr_data;
        end
    end

    always_comb begin
        next_data1 = mem[rd_addr1];
        if (rd_addr1 == '0) begin
            next_data1 = '0;
        end else if (wr_live && (wr_addr == rd_addr1)) begin
            next_data1 = wr_data;
        end
    end

    // Reset wins over any write or read presented on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data0 <= '0;
            rd_data1 <= '0;
        end else begin
            if (wr_live) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en0) begin
                rd_data0 <= next_data0;
            end
            if (rd_en1) begin
                rd_data1 <= next_data1;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: reset, write/read, forwarding, r0, hold,
// reset priority and the downstream 2:1 operand mux.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en0;
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic        rd_en1;
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    // Operand mux downstream of port 1: in0 = register operand, in1 = immediate.
    logic        sel;
    logic [31:0] imm;
    logic [31:0] mux_out;
    assign mux_out = sel ? imm : rd_data1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en0   (rd_en0),
        .rd_addr0 (rd_addr0),
        .rd_data0 (rd_data0),
        .rd_en1   (rd_en1),
        .rd_addr1 (rd_addr1),
        .rd_data1 (rd_data1),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rd_en0   = 1'b1;
        rd_addr0 = 5'd5;
        rd_en1   = 1'b1;
        rd_addr1 = 5'd31;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        sel      = 1'b0;
        imm      = '0;

        // Reset for two edges.
        step();
        step();
        check("reset_rd0", rd_data0, 32'h0);
        check("reset_rd1", rd_data1, 32'h0);

        // Every entry reads zero after reset.
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            step();
            check($sformatf("clear_p0_r%0d", i), rd_data0, 32'h0);
            check($sformatf("clear_p1_r%0d", 31 - i), rd_data1, 32'h0);
        end

        // Write then read.
        rd_en0 = 1'b0;
        rd_en1 = 1'b0;
        do_write(5'd7, 32'hDEADBEEF);
        rd_en0   = 1'b1;
        rd_addr0 = 5'd7;
        step();
        check("wr_rd_r7", rd_data0, 32'hDEADBEEF);

        // Forwarding beats the old stored value.
        rd_en0 = 1'b0;
        do_write(5'd9, 32'h11111111);
        rd_en1   = 1'b1;
        rd_addr1 = 5'd9;
        wr_en    = 1'b1;
        wr_addr  = 5'd9;
        wr_data  = 32'h12345678;
        step();
        wr_en = 1'b0;
        check("fwd_p1_r9", rd_data1, 32'h12345678);
        step();
        check("stored_r9", rd_data1, 32'h12345678);

        // Both ports forward at once.
        rd_en0   = 1'b1;
        rd_addr0 = 5'd10;
        rd_addr1 = 5'd10;
        wr_en    = 1'b1;
        wr_addr  = 5'd10;
        wr_data  = 32'hCAFEF00D;
        step();
        wr_en = 1'b0;
        check("fwd_both_p0", rd_data0, 32'hCAFEF00D);
        check("fwd_both_p1", rd_data1, 32'hCAFEF00D);

        // r0 is hardwired: write dropped, no forwarding.
        rd_addr0 = 5'd0;
        rd_addr1 = 5'd0;
        wr_en    = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hFFFFFFFF;
        step();
        wr_en = 1'b0;
        check("r0_fwd_p0", rd_data0, 32'h0);
        check("r0_fwd_p1", rd_data1, 32'h0);
        step();
        check("r0_later", rd_data0, 32'h0);

        // Boundary addresses.
        do_write(5'd31, 32'h80000001);
        do_write(5'd1, 32'h7FFFFFFE);
        rd_addr0 = 5'd31;
        rd_addr1 = 5'd1;
        step();
        check("r31_p0", rd_data0, 32'h80000001);
        check("r1_p1", rd_data1, 32'h7FFFFFFE);

        // Hold with rd_en0 low.
        rd_addr0 = 5'd7;
        step();
        check("pre_hold", rd_data0, 32'hDEADBEEF);
        rd_en0   = 1'b0;
        rd_addr0 = 5'd9;
        step();
        check("hold_a", rd_data0, 32'hDEADBEEF);
        rd_addr0 = 5'd0;
        step();
        check("hold_b", rd_data0, 32'hDEADBEEF);

        // Reset has priority over a same-edge write.
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'hA5A5A5A5;
        step();
        check("rst_mid_rd0", rd_data0, 32'h0);
        check("rst_mid_rd1", rd_data1, 32'h0);
        rst_n    = 1'b1;
        wr_en    = 1'b0;
        rd_en0   = 1'b1;
        rd_addr0 = 5'd3;
        rd_addr1 = 5'd7;
        step();
        check("r3_after_rst", rd_data0, 32'h0);
        check("r7_after_rst", rd_data1, 32'h0);

        // Mux integration through port 1.
        do_write(5'd4, 32'h000000FF);
        rd_en1   = 1'b1;
        rd_addr1 = 5'd4;
        imm      = 32'hFFFFFFFF;
        sel      = 1'b0;
        step();
        check("mux_sel0", mux_out, 32'h000000FF);
        sel = 1'b1;
        #1;
        check("mux_sel1", mux_out, 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
